// File: rtl/mmp_iddmm_host_if.sv
// Bundle of job-input, result-output and multiplier-side signals for mmp_iddmm_host.
// The master modport is the host block itself; the slave modport is whatever sits
// around it (job source, result sink and the multiplier core).
interface mmp_iddmm_host_if #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = (N > 1) ? $clog2(N) : 1
);
  // job operand stream
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_mask;
  logic [K-1:0]      in_x;
  logic [K-1:0]      in_y;
  logic [K-1:0]      in_m;
  logic [K-1:0]      in_m1;

  // result stream
  logic              res_valid;
  logic              res_ready;
  logic [K-1:0]      res_data;
  logic              res_last;

  // status
  logic              busy;
  logic              err;

  // multiplier task interface
  logic [2:0]        mm_wr_ena;
  logic [ADDR_W-1:0] mm_wr_addr;
  logic [K-1:0]      mm_wr_x;
  logic [K-1:0]      mm_wr_y;
  logic [K-1:0]      mm_wr_m;
  logic [K-1:0]      mm_wr_m1;
  logic              mm_task_req;
  logic              mm_task_end;
  logic              mm_task_grant;
  logic [K-1:0]      mm_task_res;

  modport master (
    input  in_valid, in_mask, in_x, in_y, in_m, in_m1,
    output in_ready,
    output res_valid, res_data, res_last,
    input  res_ready,
    output busy, err,
    output mm_wr_ena, mm_wr_addr, mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1, mm_task_req,
    input  mm_task_end, mm_task_grant, mm_task_res
  );

  modport slave (
    output in_valid, in_mask, in_x, in_y, in_m, in_m1,
    input  in_ready,
    input  res_valid, res_data, res_last,
    output res_ready,
    input  busy, err,
    input  mm_wr_ena, mm_wr_addr, mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1, mm_task_req,
    output mm_task_end, mm_task_grant, mm_task_res
  );
endinterface

// File: rtl/mmp_iddmm_host.sv
// Initiator for the mmp_iddmm_sp multiplier: loads one job's operand words into
// the multiplier RAMs, kicks the task, buffers the granted result words and
// replays them on a back-pressurable result stream.
// K, N and ADDR_W must match both the interface instance and the multiplier.
module mmp_iddmm_host #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = (N > 1) ? $clog2(N) : 1
) (
  input logic                   clk,
  input logic                   rst_n,
  mmp_iddmm_host_if.master      bus
);

  // result counter must be able to hold the value N itself (saturation point)
  localparam int CW = $clog2(N + 1);
  localparam logic [ADDR_W-1:0] LAST_W = ADDR_W'(N - 1);
  localparam logic [CW-1:0]     N_C    = CW'(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_kick_wait;
  logic              r_task_req;
  logic              r_res_valid;
  logic              r_err;
  logic [2:0]        r_mask;
  logic [2:0]        r_wr_ena;
  logic [ADDR_W-1:0] r_wcnt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rcnt;
  logic [CW-1:0]     r_gcnt;
  logic [K-1:0]      r_m1;
  logic [K-1:0]      r_wr_x;
  logic [K-1:0]      r_wr_y;
  logic [K-1:0]      r_wr_m;
  logic [K-1:0]      r_buf [N];

  logic              w_accept;
  logic              w_grant_take;
  logic [CW-1:0]     w_gcnt_final;

  // in_ready is only ever high in IDLE/LOAD, so an accept implies one of those states
  assign w_accept     = bus.in_valid & r_in_ready;
  // grants beyond N are dropped so the buffer index never overruns
  assign w_grant_take = (r_state == S_RUN) & bus.mm_task_grant & (r_gcnt != N_C);
  assign w_gcnt_final = w_grant_take ? (r_gcnt + CW'(1)) : r_gcnt;

  // Job sequencer: operand load, task kick, result capture count and drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_kick_wait <= 1'b0;
      r_task_req  <= 1'b0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
      r_mask      <= '0;
      r_wr_ena    <= '0;
      r_wcnt      <= '0;
      r_wr_addr   <= '0;
      r_rcnt      <= '0;
      r_gcnt      <= '0;
      r_m1        <= '0;
      r_wr_x      <= '0;
      r_wr_y      <= '0;
      r_wr_m      <= '0;
    end else begin
      r_wr_ena   <= '0;
      r_task_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            // word 0 uses the live mask since the latch happens on this same edge
            r_mask    <= bus.in_mask;
            if (bus.in_mask[2]) begin
              r_m1 <= bus.in_m1;
            end
            r_err     <= 1'b0;
            r_gcnt    <= '0;
            r_wr_ena  <= bus.in_mask;
            r_wr_addr <= '0;
            r_wr_x    <= bus.in_x;
            r_wr_y    <= bus.in_y;
            r_wr_m    <= bus.in_m;
            if (N == 1) begin
              r_state     <= S_KICK;
              r_in_ready  <= 1'b0;
              r_kick_wait <= 1'b0;
            end else begin
              r_wcnt  <= ADDR_W'(1);
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_wr_ena  <= r_mask;
            r_wr_addr <= r_wcnt;
            r_wr_x    <= bus.in_x;
            r_wr_y    <= bus.in_y;
            r_wr_m    <= bus.in_m;
            r_wcnt    <= r_wcnt + ADDR_W'(1);
            if (r_wcnt == LAST_W) begin
              r_state     <= S_KICK;
              r_in_ready  <= 1'b0;
              r_kick_wait <= 1'b0;
            end
          end
        end
        S_KICK: begin
          // one idle cycle after the final RAM write before requesting the task
          if (!r_kick_wait) begin
            r_kick_wait <= 1'b1;
          end else begin
            r_task_req <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_gcnt <= w_gcnt_final;
          if (bus.mm_task_end) begin
            r_err       <= (w_gcnt_final != N_C);
            r_rcnt      <= '0;
            r_res_valid <= 1'b1;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.res_ready) begin
            if (r_rcnt == LAST_W) begin
              r_res_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_rcnt <= r_rcnt + ADDR_W'(1);
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  // Result buffer: captures each accepted grant word; contents need no reset
  always_ff @(posedge clk) begin
    if (w_grant_take) begin
      r_buf[r_gcnt[ADDR_W-1:0]] <= bus.mm_task_res;
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.res_valid   = r_res_valid;
  // words the multiplier never granted read back as zero
  assign bus.res_data    = (r_res_valid && (CW'(r_rcnt) < r_gcnt)) ? r_buf[r_rcnt] : '0;
  assign bus.res_last    = r_res_valid & (r_rcnt == LAST_W);
  assign bus.busy        = (r_state != S_IDLE) | w_accept;
  assign bus.err         = r_err;
  assign bus.mm_wr_ena   = r_wr_ena;
  assign bus.mm_wr_addr  = r_wr_addr;
  assign bus.mm_wr_x     = r_wr_x;
  assign bus.mm_wr_y     = r_wr_y;
  assign bus.mm_wr_m     = r_wr_m;
  assign bus.mm_wr_m1    = r_m1;
  assign bus.mm_task_req = r_task_req;

endmodule
